// File: rtl/div_clk_gen_pkg.sv
// Shared constants and the configuration clamp for the programmable clock divider.
package div_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_PERIOD_VAL = 9;
  localparam int DEF_HIGH_VAL   = 5;

  typedef struct packed {
    logic [31:0] per;
    logic [31:0] high;
  } div_cfg_t;

  // Guarantees at least one high and one low cycle in every period.
  function automatic div_cfg_t div_clamp(input logic [31:0] period, input logic [31:0] high);
    div_cfg_t res;
    res.per = (period == 32'd0) ? 32'd1 : period;
    if (high == 32'd0)
      res.high = 32'd1;
    else if (high > res.per)
      res.high = res.per;
    else
      res.high = high;
    return res;
  endfunction

endpackage

// File: rtl/div_clk_gen_if.sv
// Bus between the divider and its controller; SYNC exists only when DIV_SYNC_EN is defined.
interface div_clk_gen_if #(
    parameter int CNT_W = 16
);

    // LOAD is a single-cycle request with no ready: it is accepted on every edge it is high.
    logic             EN;
    logic             LOAD;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH;
`ifdef DIV_SYNC_EN
    logic             SYNC;
`endif
    logic             DIV_CLK;
    logic             RISING_EDGE;
    logic             FALLING_EDGE;
    logic             PERIOD_END;
    logic [CNT_W-1:0] PHASE;
    logic             PENDING;

    modport master (
        output EN, LOAD, PERIOD, HIGH,
`ifdef DIV_SYNC_EN
        output SYNC,
`endif
        input  DIV_CLK, RISING_EDGE, FALLING_EDGE, PERIOD_END, PHASE, PENDING
    );

    modport slave (
        input  EN, LOAD, PERIOD, HIGH,
`ifdef DIV_SYNC_EN
        input  SYNC,
`endif
        output DIV_CLK, RISING_EDGE, FALLING_EDGE, PERIOD_END, PHASE, PENDING
    );

endinterface

// File: rtl/div_clk_gen_cfg_shadow.sv
// Active/shadow configuration registers; new settings only land on a period wrap.
module div_cfg_shadow
    import div_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_VAL,
    parameter int DEF_HIGH   = DEF_HIGH_VAL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             wrap,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic [CNT_W-1:0] per_a,
    output logic [CNT_W-1:0] high_a,
    output logic [CNT_W-1:0] per_nx,
    output logic [CNT_W-1:0] high_nx,
    output logic             pending
);

    localparam div_cfg_t         DEF_C      = div_clamp(32'(DEF_PERIOD), 32'(DEF_HIGH));
    localparam logic [CNT_W-1:0] DEF_PER_A  = DEF_C.per[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DEF_HIGH_A = DEF_C.high[CNT_W-1:0];

    div_cfg_t         load_c;
    logic [CNT_W-1:0] load_per, load_high;
    logic [CNT_W-1:0] per_q, high_q, per_s, high_s, per_s_nx, high_s_nx;
    logic             pend_q, pend_nx;

    always_comb begin
        load_c    = div_clamp(32'(period), 32'(high));
        load_per  = load_c.per[CNT_W-1:0];
        load_high = load_c.high[CNT_W-1:0];
    end

    // A load coinciding with the wrap wins over an older pending shadow.
    always_comb begin
        per_nx    = per_q;
        high_nx   = high_q;
        per_s_nx  = per_s;
        high_s_nx = high_s;
        pend_nx   = pend_q;
        if (wrap) begin
            if (load) begin
                per_nx  = load_per;
                high_nx = load_high;
            end else if (pend_q) begin
                per_nx  = per_s;
                high_nx = high_s;
            end
            pend_nx = 1'b0;
        end else if (load) begin
            per_s_nx  = load_per;
            high_s_nx = load_high;
            pend_nx   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            per_q  <= DEF_PER_A;
            high_q <= DEF_HIGH_A;
            per_s  <= DEF_PER_A;
            high_s <= DEF_HIGH_A;
            pend_q <= 1'b0;
        end else begin
            per_q  <= per_nx;
            high_q <= high_nx;
            per_s  <= per_s_nx;
            high_s <= high_s_nx;
            pend_q <= pend_nx;
        end
    end

    assign per_a   = per_q;
    assign high_a  = high_q;
    assign pending = pend_q;

endmodule

// File: rtl/div_clk_gen.sv
// Programmable clock divider with registered edge/period strobes.
// Optional phase restart input SYNC is built when DIV_SYNC_EN is defined.
module div_clk_gen
    import div_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_VAL,
    parameter int DEF_HIGH   = DEF_HIGH_VAL
) (
    input logic        CLK,
    input logic        RST,
    div_clk_gen_if.slave bus
);

    // Counter resets to the clamped period so the first enabled edge is a wrap.
    localparam div_cfg_t         DEF_C     = div_clamp(32'(DEF_PERIOD), 32'(DEF_HIGH));
    localparam logic [CNT_W-1:0] DEF_PER_A = DEF_C.per[CNT_W-1:0];

    logic [CNT_W-1:0] cnt, cnt_nx, per_a, high_a, per_nx, high_nx;
    logic             adv, sync_req, wrap;
    logic             div_q, div_nx, rise_q, fall_q, pe_q;

`ifdef DIV_SYNC_EN
    assign sync_req = bus.SYNC;
`else
    assign sync_req = 1'b0;
`endif

    assign adv  = bus.EN;
    assign wrap = adv & ((cnt == per_a) | sync_req);

    div_cfg_shadow #(
        .CNT_W     (CNT_W),
        .DEF_PERIOD(DEF_PERIOD),
        .DEF_HIGH  (DEF_HIGH)
    ) u_cfg (
        .CLK    (CLK),
        .RST    (RST),
        .load   (bus.LOAD),
        .wrap   (wrap),
        .period (bus.PERIOD),
        .high   (bus.HIGH),
        .per_a  (per_a),
        .high_a (high_a),
        .per_nx (per_nx),
        .high_nx(high_nx),
        .pending(bus.PENDING)
    );

    always_comb begin
        cnt_nx = cnt;
        div_nx = div_q;
        if (adv) begin
            cnt_nx = wrap ? '0 : cnt + 1'b1;
            div_nx = (cnt_nx < high_nx);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= DEF_PER_A;
            div_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            div_q  <= div_nx;
            rise_q <= adv & div_nx & ~div_q;
            fall_q <= adv & ~div_nx & div_q;
            pe_q   <= adv & (cnt_nx == per_nx);
        end
    end

    assign bus.PHASE        = cnt;
    assign bus.DIV_CLK      = div_q;
    assign bus.RISING_EDGE  = rise_q;
    assign bus.FALLING_EDGE = fall_q;
    assign bus.PERIOD_END   = pe_q;

endmodule

// File: doc/div_clk_gen.md
# div_clk_gen

Parametrised programmable clock divider. It generalises the fixed 50 %-duty, N+1 divider to a configurable counter width, a programmable high time, and glitch-free reconfiguration that takes effect only at a period boundary. It also provides a phase output and a period-end strobe, plus an optional phase-alignment input. It sits between the system clock and the ADC/PLL timing logic, which consume `DIV_CLK` as a clock-enable-style waveform and the edge strobes as single-cycle events.

## Interface
- `CNT_W`, 16: counter/configuration width in bits (≥2).
- `DEF_PERIOD`, 9: active period value loaded at reset (period length = value+1 cycles).
- `DEF_HIGH`, 5: active high-time loaded at reset.
- `CLK` in 1: the single clock; all logic on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `EN` in 1: 1 = counter advances; 0 = freeze.
- `PERIOD` in CNT_W: requested period value; the period is PERIOD+1 cycles.
- `HIGH` in CNT_W: requested high time in cycles.
- `LOAD` in 1: single-cycle request to capture `PERIOD`/`HIGH`.
- `SYNC` in 1: phase restart. Present only with `DIV_SYNC_EN`.
- `DIV_CLK` out 1: divided waveform.
- `RISING_EDGE` out 1: 1 in the cycle `DIV_CLK` first reads 1.
- `FALLING_EDGE` out 1: 1 in the cycle `DIV_CLK` first reads 0.
- `PERIOD_END` out 1: 1 in the cycle `PHASE` first equals the active period.
- `PHASE` out CNT_W: current counter value.
- `PENDING` out 1: a captured configuration is waiting for the boundary.

## Operation
- **Active registers.** `per_a` and `high_a` hold the active configuration. The shadow registers `per_s` and `high_s` hold captured values, flagged by `pending`.
- **Clamping** is applied when the active registers are written:
  - per = max(PERIOD, 1)
  - high = 1 if HIGH = 0; per if HIGH > per; otherwise HIGH
  - Result: every period has ≥1 high cycle and ≥1 low cycle. Minimum period is 2 cycles.
- **Counter.** `cnt` runs 0..`per_a`, then wraps to 0. `DIV_CLK` = (`cnt` < `high_a`), registered together with `cnt`.
- **Advance.** With `EN`=1, each cycle computes `cnt_next` = (`cnt`==`per_a`) ? 0 : `cnt`+1.
  - At a wrap with `pending`=1: `per_a`/`high_a` take the shadow values, `pending` clears, and the new period starts at `cnt`=0 using the new high time.
- **LOAD.**
  - Captures `PERIOD`/`HIGH` into the shadow registers and sets `pending`.
  - A `LOAD` while already pending overwrites the shadow (last write wins).
  - A `LOAD` in the wrap cycle is applied at that wrap directly, bypassing the shadow; `pending` stays 0.
  - `LOAD` is accepted regardless of `EN`.
- **EN=0.** `cnt`, `DIV_CLK` and `PHASE` hold. All strobes are 0. A pending configuration waits until the next wrap after `EN` returns.
- **Strobes.** All strobes are registered, one cycle wide, and aligned with the `DIV_CLK`/`PHASE` change that causes them.
  - `RISING_EDGE` = `div_next` & ~`DIV_CLK`.
  - `FALLING_EDGE` = ~`div_next` & `DIV_CLK`.
  - `PERIOD_END` = (`cnt_next`==`per_next`) & advancing.
- **Reset values.**
  - `cnt`=`DEF_PERIOD`, so the first enabled cycle wraps.
  - `DIV_CLK`=0, all strobes 0, `PENDING`=0.
  - `per_a`/`high_a` = clamped `DEF_PERIOD`/`DEF_HIGH`.
  - Reset mid-period aborts immediately; a pending configuration is discarded.

## Timing
- **Latency.** Edge k samples `EN`=1; after edge k, `PHASE`=0, `DIV_CLK`=1 and `RISING_EDGE`=1. There is no further pipeline.
- **Defaults (9/5).**
  - `DIV_CLK` is high for `PHASE` 0..4 and low for 5..9.
  - `FALLING_EDGE` fires at `PHASE`=5; `PERIOD_END` fires at `PHASE`=9.
- **Reconfiguration latency.** A new configuration appears ≤ one old period after `LOAD`; it never truncates or stretches the current period.

## Configuration
- **`DIV_SYNC_EN` defined:** the `SYNC` port exists.
  - `SYNC`=1 with `EN`=1 forces `cnt_next`=0 as a wrap, including applying any pending configuration.
  - `RISING_EDGE` fires only if `DIV_CLK` was 0.
  - `PERIOD_END` is not asserted by a sync.
  - `SYNC` with `EN`=0 is ignored.
  - `SYNC` together with a natural wrap behaves as a single wrap.
- **`DIV_SYNC_EN` undefined:** there is no `SYNC` port; behaviour is identical to `SYNC` tied 0.

## Structure
- **Package `div_pkg`:**
  - default `CNT_W`, `DEF_PERIOD`, `DEF_HIGH` constants;
  - the clamp function (period/high → clamped pair).
- **Sub-module `div_cfg_shadow`:** shadow registers, `pending` flag, LOAD/wrap arbitration and clamping. Its output is the active `per_a`/`high_a`. The counter and waveform logic stay in `div_clk_gen`.

## Test plan
- **Defaults:** reset, then `EN`=1 → 10-cycle period, `DIV_CLK` high 5 / low 5. `RISING_EDGE` at `PHASE` 0, `FALLING_EDGE` at 5, `PERIOD_END` at 9, all one cycle wide.
- **Mid-period load:** `LOAD` `PERIOD`=3 `HIGH`=1 at `PHASE`=2 → `PENDING`=1 and the current period completes at 10 cycles. Then a 4-cycle period with high 1 / low 3, and `PENDING`=0.
- **Clamping and wrap-cycle load:**
  - `LOAD` `PERIOD`=0 `HIGH`=0 → `DIV_CLK` = CLK/2 (high 1, low 1).
  - `LOAD` `PERIOD`=4 `HIGH`=20 → high 4, low 1.
  - `LOAD` issued exactly in a `PERIOD_END` cycle → applied at that wrap, `PENDING` never set.
- **Freeze:** `EN`=0 at `PHASE`=3 for 7 cycles → `PHASE` holds 3, `DIV_CLK` holds 1, no strobes. After resume, `PHASE` goes 4, and `FALLING_EDGE` fires at 5.
- **Sync (`DIV_SYNC_EN`):** `SYNC` at `PHASE`=6 → next `PHASE`=0, `RISING_EDGE`=1, no `PERIOD_END`. `SYNC` at `PHASE`=2 → `PHASE`=0 with no `RISING_EDGE`.
- **Reset mid-operation:** `RST` at `PHASE`=7 with `PENDING`=1 → immediately `DIV_CLK`=0, strobes 0, `PENDING`=0, `PHASE`=9. The default configuration resumes on release.
